// File: rtl/csa_seq_ctrl.sv
// rtl/csa_seq_ctrl.sv - chunk-serial wide adder around one narrow CSA; optional subtract via CSA_SEQ_SUB_EN

// Narrow chunk adder: {co,sum} = a + b + ci
module CSA #(
  parameter int N = 3
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] sum,
  output logic         co
);
  assign {co, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
endmodule

module csa_seq_ctrl #(
  parameter int N      = 3,
  parameter int CHUNKS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N*CHUNKS-1:0] a,
  input  logic [N*CHUNKS-1:0] b,
  input  logic                ci,
`ifdef CSA_SEQ_SUB_EN
  input  logic                sub,
`endif
  output logic                busy,
  output logic                done,
  output logic [N*CHUNKS-1:0] sum,
  output logic                co
);
  localparam int W  = N * CHUNKS;
  localparam int IW = $clog2(CHUNKS);
  localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    opa_q, opa_d;
  logic [W-1:0]    opb_q, opb_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            co_q, co_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [N-1:0]    csa_a, csa_b, csa_sum;
  logic            csa_co;
  logic            accept;

  // Operand chunk selected by the current index; the only carry path between chunks is carry_q
  assign csa_a = opa_q[idx_q*N +: N];
  assign csa_b = opb_q[idx_q*N +: N];

  CSA #(.N(N)) u_csa (
    .a   (csa_a),
    .b   (csa_b),
    .ci  (carry_q),
    .sum (csa_sum),
    .co  (csa_co)
  );

  assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

  // Next-state: accept latches operands, RUN steps one chunk per cycle, DONE pulses for one cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    co_d    = co_q;

    if (accept) begin
      opa_d   = a;
`ifdef CSA_SEQ_SUB_EN
      opb_d   = sub ? ~b : b;
      carry_d = sub ? 1'b1 : ci;
`else
      opb_d   = b;
      carry_d = ci;
`endif
      idx_d   = '0;
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          acc_d[idx_q*N +: N] = csa_sum;
          carry_d = csa_co;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            sum_d   = acc_d;
            co_d    = csa_co;
            idx_d   = '0;
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // All state and outputs registered; asynchronous reset discards any in-flight add
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign co   = co_q;
endmodule
